// File: rtl/lock_equiv_checker.sv
// rtl/lock_equiv_checker.sv - multi-channel golden-vs-locked output equivalence monitor
// Compares NCH channels per clock after a warm-up window and keeps sticky flags, counts and first-failure info.
module lock_equiv_checker #(
    parameter int NCH          = 4,
    parameter int W            = 128,
    parameter int CNT_W        = 16,
    parameter int WARMUP       = 4,
    parameter int STOP_ON_FAIL = 0,
    localparam int FCH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 sys_clk_50,
    input  logic                 sync_rst_in,
    input  logic                 check_en,
    input  logic                 clear,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [NCH*W-1:0]     gold_bus,
    input  logic [NCH*W-1:0]     dut_bus,
    output logic [1:0]           state,
    output logic [NCH-1:0]       mismatch_now,
    output logic [NCH-1:0]       mismatch_flags,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 first_fail_valid,
    output logic [CNT_W-1:0]     first_fail_cycle,
    output logic [FCH_W-1:0]     first_fail_ch
);

    localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    logic [1:0]       r_state;
    logic [WU_W-1:0]  r_wu_cnt;
    logic [NCH-1:0]   r_mismatch_now;
    logic [NCH-1:0]   r_mismatch_flags;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_ff_valid;
    logic [CNT_W-1:0] r_ff_cycle;
    logic [FCH_W-1:0] r_ff_ch;

    logic [NCH-1:0]   w_diff;
    logic             w_any_diff;
    logic [FCH_W-1:0] w_low_ch;
    logic             w_err_sat;
    logic             w_cyc_sat;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_cmp
            assign w_diff[g] = ch_mask[g] & (gold_bus[g*W +: W] != dut_bus[g*W +: W]);
        end
    endgenerate

    assign w_any_diff = |w_diff;
    assign w_err_sat  = &r_err_count;
    assign w_cyc_sat  = &r_cycle_count;

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        w_low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_low_ch = FCH_W'(i);
            end
        end
    end

    always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            r_state          <= S_IDLE;
            r_wu_cnt         <= '0;
            r_mismatch_now   <= '0;
            r_mismatch_flags <= '0;
            r_err_count      <= '0;
            r_cycle_count    <= '0;
            r_ff_valid       <= 1'b0;
            r_ff_cycle       <= '0;
            r_ff_ch          <= '0;
        end else if (clear) begin
            r_state          <= S_IDLE;
            r_wu_cnt         <= '0;
            r_mismatch_now   <= '0;
            r_mismatch_flags <= '0;
            r_err_count      <= '0;
            r_cycle_count    <= '0;
            r_ff_valid       <= 1'b0;
            r_ff_cycle       <= '0;
            r_ff_ch          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (check_en) begin
                        if (WARMUP == 0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state  <= S_WARMUP;
                            r_wu_cnt <= WU_W'(WARMUP);
                        end
                    end
                end
                S_WARMUP: begin
                    if (!check_en) begin
                        r_state  <= S_IDLE;
                        r_wu_cnt <= '0;
                    end else if (r_wu_cnt <= WU_W'(1)) begin
                        r_state  <= S_CHECK;
                        r_wu_cnt <= '0;
                    end else begin
                        r_wu_cnt <= r_wu_cnt - WU_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!check_en) begin
                        r_state        <= S_IDLE;
                        r_mismatch_now <= '0;
                    end else begin
                        r_mismatch_now   <= w_diff;
                        r_mismatch_flags <= r_mismatch_flags | w_diff;
                        if (!w_cyc_sat) begin
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                        end
                        if (w_any_diff) begin
                            if (!w_err_sat) begin
                                r_err_count <= r_err_count + CNT_W'(1);
                            end
                            if (!r_ff_valid) begin
                                r_ff_valid <= 1'b1;
                                r_ff_cycle <= r_cycle_count;
                                r_ff_ch    <= w_low_ch;
                            end
                            if (STOP_ON_FAIL != 0) begin
                                r_state <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state            = r_state;
    assign mismatch_now     = r_mismatch_now;
    assign mismatch_flags   = r_mismatch_flags;
    assign err_count        = r_err_count;
    assign cycle_count      = r_cycle_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_cycle = r_ff_cycle;
    assign first_fail_ch    = r_ff_ch;

endmodule

// File: tb/tb_lock_equiv_checker.sv
// tb/tb_lock_equiv_checker.sv - directed self-checking bench for lock_equiv_checker
// Three instances: defaults, stop-on-fail, and a 4-bit counter build for saturation.
module tb_lock_equiv_checker;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         check_en = 1'b0;
    logic         clear = 1'b0;
    logic [3:0]   mask = 4'hF;
    logic [511:0] gold;
    logic [511:0] dutb;

    logic [1:0]  m_state, s_state, t_state;
    logic [3:0]  m_mn, m_flags, s_mn, s_flags, t_mn, t_flags;
    logic [15:0] m_err, m_cyc, m_ffc, s_err, s_cyc, s_ffc;
    logic [3:0]  t_err, t_cyc, t_ffc;
    logic        m_ffv, s_ffv, t_ffv;
    logic [1:0]  m_ffch, s_ffch, t_ffch;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lock_equiv_checker #(.NCH(4), .W(W), .CNT_W(16), .WARMUP(4), .STOP_ON_FAIL(0)) u_main (
        .sys_clk_50(clk), .sync_rst_in(rst), .check_en(check_en), .clear(clear), .ch_mask(mask),
        .gold_bus(gold), .dut_bus(dutb), .state(m_state), .mismatch_now(m_mn), .mismatch_flags(m_flags),
        .err_count(m_err), .cycle_count(m_cyc), .first_fail_valid(m_ffv), .first_fail_cycle(m_ffc),
        .first_fail_ch(m_ffch));

    lock_equiv_checker #(.NCH(4), .W(W), .CNT_W(16), .WARMUP(4), .STOP_ON_FAIL(1)) u_stop (
        .sys_clk_50(clk), .sync_rst_in(rst), .check_en(check_en), .clear(clear), .ch_mask(mask),
        .gold_bus(gold), .dut_bus(dutb), .state(s_state), .mismatch_now(s_mn), .mismatch_flags(s_flags),
        .err_count(s_err), .cycle_count(s_cyc), .first_fail_valid(s_ffv), .first_fail_cycle(s_ffc),
        .first_fail_ch(s_ffch));

    lock_equiv_checker #(.NCH(4), .W(W), .CNT_W(4), .WARMUP(4), .STOP_ON_FAIL(0)) u_sat (
        .sys_clk_50(clk), .sync_rst_in(rst), .check_en(check_en), .clear(clear), .ch_mask(mask),
        .gold_bus(gold), .dut_bus(dutb), .state(t_state), .mismatch_now(t_mn), .mismatch_flags(t_flags),
        .err_count(t_err), .cycle_count(t_cyc), .first_fail_valid(t_ffv), .first_fail_cycle(t_ffc),
        .first_fail_ch(t_ffch));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_diff(input logic [3:0] chans);
        dutb = gold;
        for (int i = 0; i < 4; i++) begin
            if (chans[i]) dutb[i*W + 77] = ~dutb[i*W + 77];
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        check_en = 1'b1; mask = 4'hF; set_diff(4'b0100);
        ticks(10);
        n_checks++; if (m_err !== 16'd5) begin n_fail++; $display("FAIL rst_pre_err got=%0d exp=5", m_err); end
        n_checks++; if (m_state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_state got=%0d exp=2", m_state); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (m_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", m_state); end
        n_checks++; if (m_err !== 16'd0 || m_cyc !== 16'd0) begin n_fail++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", m_err, m_cyc); end
        n_checks++; if (m_mn !== 4'd0 || m_flags !== 4'd0) begin n_fail++; $display("FAIL rst_flags got=%b/%b exp=0000/0000", m_mn, m_flags); end
        n_checks++; if (m_ffv !== 1'b0 || m_ffc !== 16'd0 || m_ffch !== 2'd0) begin n_fail++; $display("FAIL rst_ff got=%b/%0d/%0d exp=0/0/0", m_ffv, m_ffc, m_ffch); end
        rst = 1'b0; check_en = 1'b0; set_diff(4'b0000);
        ticks(10);
        n_checks++; if (m_state !== 2'd0 || m_err !== 16'd0 || m_cyc !== 16'd0) begin n_fail++; $display("FAIL idle_hold got=%0d/%0d/%0d exp=0/0/0", m_state, m_err, m_cyc); end
    endtask

    task automatic test_clean_run();
        int n_warm;
        n_warm = 0;
        check_en = 1'b1; mask = 4'hF; set_diff(4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_state == 2'd1) n_warm++;
            else break;
        end
        n_checks++; if (n_warm !== 4) begin n_fail++; $display("FAIL warm_len got=%0d exp=4", n_warm); end
        n_checks++; if (m_state !== 2'd2 || m_cyc !== 16'd0) begin n_fail++; $display("FAIL enter_check got=%0d/%0d exp=2/0", m_state, m_cyc); end
        ticks(16);
        n_checks++; if (m_cyc !== 16'd16) begin n_fail++; $display("FAIL clean_cyc got=%0d exp=16", m_cyc); end
        n_checks++; if (m_err !== 16'd0 || m_flags !== 4'd0 || m_ffv !== 1'b0) begin n_fail++; $display("FAIL clean_stats got=%0d/%b/%b exp=0/0000/0", m_err, m_flags, m_ffv); end
        check_en = 1'b0;
        tick();
        n_checks++; if (m_state !== 2'd0 || m_cyc !== 16'd16) begin n_fail++; $display("FAIL clean_exit got=%0d/%0d exp=0/16", m_state, m_cyc); end
    endtask

    task automatic test_warmup_mask();
        do_clear();
        n_checks++; if (m_state !== 2'd0 || m_cyc !== 16'd0) begin n_fail++; $display("FAIL clear_zero got=%0d/%0d exp=0/0", m_state, m_cyc); end
        check_en = 1'b1; mask = 4'hF; set_diff(4'b0010);
        ticks(5);
        n_checks++; if (m_state !== 2'd2 || m_err !== 16'd0 || m_flags !== 4'd0 || m_mn !== 4'd0) begin n_fail++; $display("FAIL warm_ignore got=%0d/%0d/%b/%b exp=2/0/0000/0000", m_state, m_err, m_flags, m_mn); end
        set_diff(4'b0000);
        ticks(5);
        set_diff(4'b0010);
        tick();
        n_checks++; if (m_flags !== 4'b0010 || m_mn !== 4'b0010) begin n_fail++; $display("FAIL wm_flags got=%b/%b exp=0010/0010", m_flags, m_mn); end
        n_checks++; if (m_ffv !== 1'b1 || m_ffc !== 16'd5 || m_ffch !== 2'd1) begin n_fail++; $display("FAIL wm_first got=%b/%0d/%0d exp=1/5/1", m_ffv, m_ffc, m_ffch); end
        n_checks++; if (m_err !== 16'd1 || m_cyc !== 16'd6) begin n_fail++; $display("FAIL wm_counts got=%0d/%0d exp=1/6", m_err, m_cyc); end
        set_diff(4'b0000);
        tick();
        n_checks++; if (m_mn !== 4'b0000 || m_flags !== 4'b0010) begin n_fail++; $display("FAIL wm_sticky got=%b/%b exp=0000/0010", m_mn, m_flags); end
    endtask

    task automatic test_multi_mask();
        do_clear();
        check_en = 1'b1; mask = 4'b1110; set_diff(4'b1001);
        ticks(5);
        ticks(3);
        n_checks++; if (m_flags !== 4'b1000 || m_mn !== 4'b1000) begin n_fail++; $display("FAIL mm_flags got=%b/%b exp=1000/1000", m_flags, m_mn); end
        n_checks++; if (m_ffch !== 2'd3 || m_ffc !== 16'd0 || m_err !== 16'd3) begin n_fail++; $display("FAIL mm_first got=%0d/%0d/%0d exp=3/0/3", m_ffch, m_ffc, m_err); end
        check_en = 1'b0;
        tick();
        n_checks++; if (m_state !== 2'd0 || m_mn !== 4'd0 || m_err !== 16'd3) begin n_fail++; $display("FAIL mm_exit got=%0d/%b/%0d exp=0/0000/3", m_state, m_mn, m_err); end
        check_en = 1'b1; set_diff(4'b0001);
        ticks(5);
        ticks(2);
        n_checks++; if (m_err !== 16'd3 || m_cyc !== 16'd5 || m_flags !== 4'b1000) begin n_fail++; $display("FAIL mm_masked got=%0d/%0d/%b exp=3/5/1000", m_err, m_cyc, m_flags); end
        mask = 4'b1111;
        tick();
        n_checks++; if (m_err !== 16'd4 || m_flags !== 4'b1001 || m_mn !== 4'b0001 || m_ffch !== 2'd3) begin n_fail++; $display("FAIL mm_unmask got=%0d/%b/%b/%0d exp=4/1001/0001/3", m_err, m_flags, m_mn, m_ffch); end
        check_en = 1'b0;
        tick();
    endtask

    task automatic test_stop_on_fail();
        do_clear();
        check_en = 1'b1; mask = 4'hF; set_diff(4'b0000);
        ticks(5);
        n_checks++; if (s_state !== 2'd2) begin n_fail++; $display("FAIL sf_check got=%0d exp=2", s_state); end
        ticks(7);
        set_diff(4'b0100);
        tick();
        n_checks++; if (s_state !== 2'd3) begin n_fail++; $display("FAIL sf_halt got=%0d exp=3", s_state); end
        n_checks++; if (s_err !== 16'd1 || s_cyc !== 16'd8 || s_ffc !== 16'd7 || s_ffch !== 2'd2) begin n_fail++; $display("FAIL sf_stats got=%0d/%0d/%0d/%0d exp=1/8/7/2", s_err, s_cyc, s_ffc, s_ffch); end
        set_diff(4'b1111);
        for (int i = 0; i < 50; i++) begin
            check_en = i[0];
            tick();
        end
        n_checks++; if (s_state !== 2'd3 || s_err !== 16'd1 || s_cyc !== 16'd8) begin n_fail++; $display("FAIL sf_frozen got=%0d/%0d/%0d exp=3/1/8", s_state, s_err, s_cyc); end
        n_checks++; if (s_flags !== 4'b0100 || s_mn !== 4'b0100) begin n_fail++; $display("FAIL sf_frozen_flags got=%b/%b exp=0100/0100", s_flags, s_mn); end
        check_en = 1'b1;
        do_clear();
        n_checks++; if (s_state !== 2'd0 || s_err !== 16'd0 || s_cyc !== 16'd0 || s_flags !== 4'd0 || s_ffv !== 1'b0) begin n_fail++; $display("FAIL sf_clear got=%0d/%0d/%0d/%b/%b exp=0/0/0/0000/0", s_state, s_err, s_cyc, s_flags, s_ffv); end
        tick();
        n_checks++; if (s_state !== 2'd1) begin n_fail++; $display("FAIL sf_rearm got=%0d exp=1", s_state); end
        check_en = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_en = 1'b1; mask = 4'hF; set_diff(4'b0001);
        ticks(5);
        ticks(15);
        n_checks++; if (t_err !== 4'd15 || t_cyc !== 4'd15) begin n_fail++; $display("FAIL sat_reach got=%0d/%0d exp=15/15", t_err, t_cyc); end
        ticks(5);
        n_checks++; if (t_err !== 4'd15 || t_cyc !== 4'd15 || t_state !== 2'd2) begin n_fail++; $display("FAIL sat_hold got=%0d/%0d/%0d exp=15/15/2", t_err, t_cyc, t_state); end
        n_checks++; if (t_ffc !== 4'd0 || t_ffch !== 2'd0 || t_flags !== 4'b0001 || t_mn !== 4'b0001) begin n_fail++; $display("FAIL sat_diag got=%0d/%0d/%b/%b exp=0/0/0001/0001", t_ffc, t_ffch, t_flags, t_mn); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (t_state !== 2'd0 || t_err !== 4'd0 || t_cyc !== 4'd0 || t_flags !== 4'd0 || t_ffv !== 1'b0) begin n_fail++; $display("FAIL sat_rst got=%0d/%0d/%0d/%b/%b exp=0/0/0/0000/0", t_state, t_err, t_cyc, t_flags, t_ffv); end
        rst = 1'b0; check_en = 1'b0;
        tick();
    endtask

    initial begin
        gold = {4{128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
        set_diff(4'b0000);
        ticks(2);
        n_checks++; if (m_state !== 2'd0 || m_err !== 16'd0 || m_ffv !== 1'b0) begin n_fail++; $display("FAIL init_rst got=%0d/%0d/%b exp=0/0/0", m_state, m_err, m_ffv); end
        rst = 1'b0;
        test_reset();
        test_clean_run();
        test_warmup_mask();
        test_multi_mask();
        test_stop_on_fail();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_equiv_checker.md
Name: lock_equiv_checker

Overview:
Multi-channel, parametrised equivalence checker for logic-locking evaluation. It compares NCH output buses of the golden design against the locked design every clock while checking is enabled. After a warm-up window it accumulates sticky per-channel mismatch flags, a saturating error count and first-failure diagnostics. It replaces per-signal assertion checks with one reusable, synthesizable monitor that can also sit on an emulation or FPGA harness.

Parameters:
NCH, 4, number of compared channels (>=1)
W, 128, width of each channel
CNT_W, 16, width of counters and cycle stamps
WARMUP, 4, cycles ignored after check_en rises (0 = none)
STOP_ON_FAIL, 0, 1 = freeze in HALT on first mismatch

Ports:
sys_clk_50  in  1  clock, rising edge
sync_rst_in  in  1  asynchronous active-high reset
check_en  in  1  level enable for checking
clear  in  1  synchronous clear of all statistics, returns to IDLE
ch_mask  in  NCH  1 = channel compared
gold_bus  in  NCH*W  golden outputs; channel i = bits [i*W +: W]
dut_bus  in  NCH*W  locked-design outputs, same packing
state  out  2  0=IDLE 1=WARMUP 2=CHECK 3=HALT
mismatch_now  out  NCH  registered per-channel mismatch of previous CHECK cycle
mismatch_flags  out  NCH  sticky per-channel mismatch
err_count  out  CNT_W  CHECK cycles with >=1 mismatch, saturating
cycle_count  out  CNT_W  CHECK cycles elapsed, saturating
first_fail_valid  out  1  first failure captured
first_fail_cycle  out  CNT_W  cycle_count value at first failure
first_fail_ch  out  max(1,$clog2(NCH))  lowest-index failing channel at first failure

Behaviour:
- Reset (async, any time, including mid-CHECK or in HALT): state=IDLE; all outputs 0; warm-up counter 0.
- Priority per edge: reset > clear > state logic. clear zeroes all outputs and forces IDLE regardless of check_en; IDLE may be left on the following edge.
- diff[i] = ch_mask[i] & (gold ch i != dut ch i). Inputs are sampled on the rising edge; every output reflects that sample one cycle later.
- IDLE: statistics held. check_en=1 -> WARMUP with counter=WARMUP, or directly to CHECK if WARMUP=0.
- WARMUP: counter decrements each cycle; diff ignored; mismatch_now=0. Counter==1 -> CHECK. check_en=0 -> IDLE, counter discarded.
- CHECK, each edge with check_en=1:
  - mismatch_now <= diff; mismatch_flags |= diff.
  - If |diff: err_count+1, saturating at all-ones.
  - If |diff and !first_fail_valid: first_fail_valid=1; first_fail_cycle=current cycle_count (pre-increment); first_fail_ch=lowest set index of diff.
  - cycle_count+1, saturating.
  - If |diff and STOP_ON_FAIL=1 -> HALT; that cycle's update is still applied.
- CHECK with check_en=0: -> IDLE, mismatch_now<=0, statistics retained.
- Re-entering CHECK from IDLE accumulates onto retained statistics; only clear or reset zeroes them.
- HALT: all outputs frozen; check_en ignored; exit only via clear or reset.
- ch_mask changes take effect on the same edge. A masked channel never sets flags.
- Simultaneous mismatch on several channels: one err_count increment; first_fail_ch=lowest index.
- Saturation: once at all-ones, counters stay there; comparison continues.

Test Plan:
- Reset/idle: assert sync_rst_in asynchronously between edges -> all outputs 0 immediately, state=0; release, check_en=0 for 10 cycles -> unchanged.
- Clean run, WARMUP=4: gold=dut, check_en high for 20 cycles -> 4 WARMUP cycles, then cycle_count=16, err_count=0, flags=0.
- Warm-up masking: mismatch on ch1 only during WARMUP cycles -> err_count=0, flags=0; same mismatch at CHECK cycle 5 -> flags=4'b0010, first_fail_cycle=5, first_fail_ch=1, err_count=1.
- Multi-channel and mask: ch0 and ch3 differ, ch_mask=4'b1110 -> flags=4'b1000, first_fail_ch=3; 3 such cycles -> err_count=3.
- STOP_ON_FAIL=1: first mismatch at CHECK cycle 7 -> state=3 and counters frozen for 50 cycles; clear -> all 0, IDLE; check_en -> WARMUP.
- Saturation, CNT_W=4: persistent mismatch for 20 CHECK cycles -> err_count=15, cycle_count=15; reset mid-CHECK -> all 0.
